// File: rtl/osd_pkg.sv
// Shared definitions for the OSD SPI sequencer: opcodes, FSM states, buffer geometry.
package osd_pkg;

  // Command opcode field (cmd[7:3])
  localparam logic [4:0] OSD_CMD_WRITE  = 5'b00100;
  localparam logic [4:0] OSD_CMD_ENABLE = 5'b01000;

  // OSD buffer geometry: 8 lines of 128 columns
  localparam int OSD_LINE_W = 3;
  localparam int OSD_COL_W  = 7;
  localparam int OSD_ADDR_W = OSD_LINE_W + OSD_COL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    SKIP  = 2'd3
  } osd_state_t;

  // Buffer address as {line, column}
  function automatic logic [OSD_ADDR_W-1:0] osd_addr(input logic [OSD_LINE_W-1:0] line,
                                                     input logic [OSD_COL_W-1:0]  col);
    return {line, col};
  endfunction

endpackage

// File: rtl/osd_sync_edge.sv
// Multi-flop synchroniser with rising-edge detect and a "chain filled" flag.
module osd_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic pclk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic primed
);

  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] fill;
  logic              prev;

  // Shift the asynchronous input through the chain and remember the last synchronised value
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: all flops here use non-blocking assignment so each stage samples the
      // previous stage's old value; blocking would collapse the chain into one flop.
      chain <= {STAGES{RESET_VAL}};
      fill  <= '0;
      prev  <= RESET_VAL;
    end else begin
      chain[0] <= async_in;
      fill[0]  <= 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
        fill[i]  <= fill[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  // prev resets to the same value as the chain, so no edge is seen right after reset
  assign sync_out = chain[STAGES-1];
  assign rise     = chain[STAGES-1] & ~prev;
  // High once every stage holds a real sample rather than the reset value
  assign primed   = fill[STAGES-1];

endmodule

// File: rtl/osd_spi_sequencer.sv
// SPI command sequencer feeding the OSD line buffer and the OSD enable flag.
module osd_spi_sequencer
  import osd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LINE_BYTES  = 256
) (
  input  logic                  pclk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  ss,
  input  logic                  sdi,
  output logic                  osd_enable,
  output logic                  buf_we,
  output logic [OSD_ADDR_W-1:0] buf_addr,
  output logic [7:0]            buf_data,
  output logic                  cmd_strobe,
  output logic [7:0]            cmd_byte
);

  localparam int BCW = $clog2(LINE_BYTES + 1);
  localparam logic [BCW-1:0] LINE_MAX = BCW'(LINE_BYTES);

  logic sck_s, sck_rise, sck_primed;
  logic ss_s, ss_rise_unused, ss_primed;
  logic sdi_s, sdi_rise_unused, sdi_primed;

  osd_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .pclk(pclk), .reset_n(reset_n), .async_in(sck),
    .sync_out(sck_s), .rise(sck_rise), .primed(sck_primed)
  );

  // NOTE: ss resets to 1 (deselected) so the sequencer cannot start a frame
  // until a real low level has been synchronised after reset.
  osd_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .pclk(pclk), .reset_n(reset_n), .async_in(ss),
    .sync_out(ss_s), .rise(ss_rise_unused), .primed(ss_primed)
  );

  osd_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .pclk(pclk), .reset_n(reset_n), .async_in(sdi),
    .sync_out(sdi_s), .rise(sdi_rise_unused), .primed(sdi_primed)
  );

  logic sck_s_unused;
  assign sck_s_unused = sck_s;

  logic primed;
  assign primed = sck_primed & ss_primed & sdi_primed;

  osd_state_t          state, state_d;
  logic                armed, armed_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [OSD_LINE_W-1:0] line_q, line_d;

  logic                  osd_enable_d, buf_we_d, cmd_strobe_d;
  logic [OSD_ADDR_W-1:0] buf_addr_d;
  logic [7:0]            buf_data_d, cmd_byte_d;

  logic [7:0]  new_byte;
  logic [15:0] k_ext;
  assign new_byte = {shift_q[6:0], sdi_s};
  assign k_ext    = 16'(byte_cnt_q);

  // Next-state and next-output logic; ss deselect overrides everything
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state;
    armed_d      = armed | (primed & ss_s);
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    line_d       = line_q;
    osd_enable_d = osd_enable;
    buf_we_d     = 1'b0;
    buf_addr_d   = buf_addr;
    buf_data_d   = buf_data;
    cmd_strobe_d = 1'b0;
    cmd_byte_d   = cmd_byte;

    if (ss_s) begin
      state_d    = IDLE;
      shift_d    = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else if (state == IDLE) begin
      // Only a frame that started after reset (ss seen high) is accepted
      if (armed) begin
        state_d    = CMD;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
      end
    end else if (sck_rise) begin
      shift_d   = new_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        unique case (state)
          CMD: begin
            cmd_byte_d   = new_byte;
            cmd_strobe_d = 1'b1;
            line_d       = new_byte[OSD_LINE_W-1:0];
            byte_cnt_d   = '0;
            if (new_byte[7:3] == OSD_CMD_WRITE) begin
              state_d = WRITE;
            end else if (new_byte[7:3] == OSD_CMD_ENABLE) begin
              osd_enable_d = new_byte[0];
              state_d      = SKIP;
            end else begin
              state_d = SKIP;
            end
          end
          WRITE: begin
            // Only odd payload bytes are stored; the count saturates at the line end
            if (byte_cnt_q[0] && (byte_cnt_q < LINE_MAX)) begin
              buf_we_d   = 1'b1;
              buf_addr_d = osd_addr(line_q, k_ext[7:1]);
              buf_data_d = new_byte;
            end
            if (byte_cnt_q < LINE_MAX) begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      line_q     <= '0;
      osd_enable <= 1'b0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      cmd_strobe <= 1'b0;
      cmd_byte   <= '0;
    end else begin
      state      <= state_d;
      armed      <= armed_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      line_q     <= line_d;
      osd_enable <= osd_enable_d;
      buf_we     <= buf_we_d;
      buf_addr   <= buf_addr_d;
      buf_data   <= buf_data_d;
      cmd_strobe <= cmd_strobe_d;
      cmd_byte   <= cmd_byte_d;
    end
  end

endmodule

// File: tb/tb_osd_spi_sequencer.sv
// Self-checking bench for osd_spi_sequencer: table of command frames plus hand-written corner cases.
module tb_osd_spi_sequencer;

  logic       pclk, reset_n, sck, ss, sdi;
  logic       osd_enable, buf_we, cmd_strobe;
  logic [9:0] buf_addr;
  logic [7:0] buf_data, cmd_byte;

  osd_spi_sequencer #(.SYNC_STAGES(2), .LINE_BYTES(256)) dut (
    .pclk(pclk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
    .osd_enable(osd_enable), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] cmd;
    int         n_pay;
    logic       exp_en;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Expected events (pushed as stimulus is driven)
  wr_t        exp_wr_q[$];
  logic [7:0] exp_cmd_q[$];
  // Observed events (recorded by the monitor only)
  wr_t        obs_wr_q[$];
  logic [7:0] obs_cmd_q[$];
  int         dbl_cnt = 0;
  logic       we_d = 1'b0, cs_d = 1'b0;
  int         wr_rd = 0, cmd_rd = 0;

  // Monitor: sample on the falling edge, away from the active edge
  always @(negedge pclk) begin
    if (buf_we) obs_wr_q.push_back({buf_addr, buf_data});
    if (cmd_strobe) obs_cmd_q.push_back(cmd_byte);
    if ((buf_we && we_d) || (cmd_strobe && cs_d)) dbl_cnt++;
    we_d = buf_we;
    cs_d = cmd_strobe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    sdi = b;
    #40 sck = 1'b1;
    #40 sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    #100;
  endtask

  task automatic frame_end();
    #100 ss = 1'b1;
    #200;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    exp_cmd_q.push_back(c);
    spi_byte(c);
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr_q.push_back(e);
  endtask

  // Compare everything expected so far against what the monitor recorded
  task automatic drain();
    wr_t        e;
    logic [7:0] c;
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      if (wr_rd < obs_wr_q.size()) begin
        check("wr_addr", 32'(obs_wr_q[wr_rd].addr), 32'(e.addr));
        check("wr_data", 32'(obs_wr_q[wr_rd].data), 32'(e.data));
        wr_rd++;
      end else begin
        check("wr_missing", 32'(obs_wr_q.size()), 32'(wr_rd + 1));
      end
    end
    check("wr_extra", 32'(obs_wr_q.size()), 32'(wr_rd));
    wr_rd = obs_wr_q.size();
    while (exp_cmd_q.size() > 0) begin
      c = exp_cmd_q.pop_front();
      if (cmd_rd < obs_cmd_q.size()) begin
        check("cmd_byte", 32'(obs_cmd_q[cmd_rd]), 32'(c));
        cmd_rd++;
      end else begin
        check("cmd_missing", 32'(obs_cmd_q.size()), 32'(cmd_rd + 1));
      end
    end
    check("cmd_extra", 32'(obs_cmd_q.size()), 32'(cmd_rd));
    cmd_rd = obs_cmd_q.size();
  endtask

  vec_t       vecs[10];
  logic [7:0] d;
  int         base;

  initial begin
    vecs[0] = '{8'h41, 0,  1'b1};
    vecs[1] = '{8'h40, 3,  1'b0};
    vecs[2] = '{8'h41, 2,  1'b1};
    vecs[3] = '{8'h10, 4,  1'b1};
    vecs[4] = '{8'h25, 10, 1'b1};
    vecs[5] = '{8'hFF, 2,  1'b1};
    vecs[6] = '{8'h40, 0,  1'b0};
    vecs[7] = '{8'h27, 6,  1'b0};
    vecs[8] = '{8'h48, 1,  1'b0};
    vecs[9] = '{8'h21, 0,  1'b0};

    reset_n = 1'b0; sck = 1'b0; ss = 1'b1; sdi = 1'b0;
    #23;
    check("rst_osd_enable", 32'(osd_enable), 32'd0);
    check("rst_buf_we",     32'(buf_we),     32'd0);
    check("rst_cmd_strobe", 32'(cmd_strobe), 32'd0);
    check("rst_buf_addr",   32'(buf_addr),   32'd0);
    check("rst_buf_data",   32'(buf_data),   32'd0);
    check("rst_cmd_byte",   32'(cmd_byte),   32'd0);
    reset_n = 1'b1;
    #100;

    // Table-driven command frames
    for (int v = 0; v < 10; v++) begin
      frame_begin();
      send_cmd(vecs[v].cmd);
      for (int k = 0; k < vecs[v].n_pay; k++) begin
        d = 8'(k * 37 + v);
        spi_byte(d);
        if (vecs[v].cmd[7:3] == 5'b00100 && k[0] && k < 256)
          push_wr({vecs[v].cmd[2:0], 7'(k >> 1)}, d);
      end
      frame_end();
      drain();
      check("tbl_osd_enable", 32'(osd_enable), 32'(vecs[v].exp_en));
      check("tbl_cmd_hold", 32'(cmd_byte), 32'(vecs[v].cmd));
    end

    // Line 3, payload 0..5: three writes at fixed addresses
    frame_begin();
    send_cmd(8'h23);
    push_wr(10'h180, 8'h01);
    push_wr(10'h181, 8'h03);
    push_wr(10'h182, 8'h05);
    for (int k = 0; k < 6; k++) spi_byte(8'(k));
    frame_end();
    drain();

    // Full line plus overrun: 128 writes, none past column 127
    base = obs_wr_q.size();
    frame_begin();
    send_cmd(8'h20);
    for (int k = 0; k < 260; k++) begin
      d = 8'(k) ^ 8'h5A;
      spi_byte(d);
      if (k[0] && k < 256) push_wr(10'(k >> 1), d);
    end
    frame_end();
    drain();
    check("line_write_count", 32'(obs_wr_q.size() - base), 32'd128);

    // Aborted byte after a write command, then a clean transfer
    frame_begin();
    send_cmd(8'h21);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    frame_end();
    drain();
    frame_begin();
    send_cmd(8'h21);
    spi_byte(8'hAA);
    push_wr(10'h080, 8'h55);
    spi_byte(8'h55);
    frame_end();
    drain();

    // ss rises together with the sck edge that completes an odd payload byte
    frame_begin();
    send_cmd(8'h22);
    spi_byte(8'h11);
    for (int i = 7; i > 0; i--) spi_bit(i[0]);
    sdi = 1'b1;
    #40;
    sck = 1'b1;
    ss  = 1'b1;
    #40 sck = 1'b0;
    #200;
    drain();

    // Unknown command leaves enable alone; async reset in the middle of its payload
    frame_begin();
    send_cmd(8'h41);
    frame_end();
    frame_begin();
    send_cmd(8'h10);
    spi_byte(8'h12);
    spi_byte(8'h34);
    for (int i = 0; i < 3; i++) spi_bit(1'b1);
    #100;
    drain();
    check("unk_osd_enable", 32'(osd_enable), 32'd1);
    check("hold_buf_addr",  32'(buf_addr),   32'h080);
    check("hold_buf_data",  32'(buf_data),   32'h55);
    @(posedge pclk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_osd_enable", 32'(osd_enable), 32'd0);
    check("arst_buf_we",     32'(buf_we),     32'd0);
    check("arst_cmd_strobe", 32'(cmd_strobe), 32'd0);
    check("arst_buf_addr",   32'(buf_addr),   32'd0);
    check("arst_buf_data",   32'(buf_data),   32'd0);
    check("arst_cmd_byte",   32'(cmd_byte),   32'd0);
    #50 reset_n = 1'b1;

    // ss still low after reset: traffic must be ignored until a fresh frame
    spi_byte(8'h41);
    spi_byte(8'h41);
    frame_end();
    drain();
    check("post_rst_osd_enable", 32'(osd_enable), 32'd0);
    frame_begin();
    send_cmd(8'h41);
    frame_end();
    drain();
    check("fresh_osd_enable", 32'(osd_enable), 32'd1);
    check("fresh_cmd_byte",   32'(cmd_byte),   32'h41);

    check("no_back_to_back_strobes", 32'(dbl_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osd_spi_sequencer.md
OSD_SPI_SEQUENCER -- requirements
Module: osd_spi_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of pclk flip-flops synchronising sck, ss and sdi.
REQ-002 Parameter LINE_BYTES, default 256, maximum payload bytes accepted per OSDCMDWRITE transfer.
REQ-003 pclk  input  1  single clock for all logic; rising edge active.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sck  input  1  SPI clock from the IO controller; asynchronous to pclk.
REQ-006 ss  input  1  SPI select, active-high deselect; asynchronous to pclk.
REQ-007 sdi  input  1  SPI data, MSB first, sampled on sck rising edge.
REQ-008 osd_enable  output  1  OSD visible flag.
REQ-009 buf_we  output  1  one-pclk write strobe into the OSD buffer.
REQ-010 buf_addr  output  10  buffer address {line[2:0], column[6:0]}.
REQ-011 buf_data  output  8  byte to be written.
REQ-012 cmd_strobe  output  1  one-pclk pulse when a command byte completes.
REQ-013 cmd_byte  output  8  last completed command byte, held until the next one.

Function
REQ-014 sck, ss and sdi shall each pass through SYNC_STAGES flops; only synchronised copies are used.
REQ-015 An sck rising edge is a cycle where synchronised sck is 1 and its previous value was 0; pclk shall be at least 4x the sck frequency.
REQ-016 States: IDLE, CMD, WRITE, SKIP; a synchronised ss of 1 forces IDLE on the next pclk from any state, discarding the partial byte, bit count and byte count.
REQ-017 IDLE -> CMD when synchronised ss is 0; bit count cleared.
REQ-018 In CMD/WRITE/SKIP each sck rising edge shifts sdi into an 8-bit shift register and increments a 3-bit bit count; the byte completes when the count wraps 7 -> 0.
REQ-019 CMD byte complete: cmd_byte updated and cmd_strobe pulsed on the next pclk; the line field is cmd[2:0] and the byte count is cleared.
REQ-020 Command 0x20..0x27 (cmd[7:3]=00100): go to WRITE.
REQ-021 Command 0x40/0x41 (cmd[7:3]=01000): osd_enable <= cmd[0] on the same cycle as cmd_strobe, then go to SKIP.
REQ-022 Any other command: go to SKIP with osd_enable unchanged.
REQ-023 WRITE byte complete with byte count k: if k is odd and k < LINE_BYTES, then buf_we=1, buf_addr={line, k[7:1]} and buf_data=byte on the next pclk. The byte count then increments.
REQ-024 Even-indexed payload bytes shall produce no write, so each line holds 128 bytes.
REQ-025 When k >= LINE_BYTES, the byte count saturates, no write occurs, and there is no address wrap into the next line.
REQ-026 SKIP consumes bits with no outputs until ss deasserts.
REQ-027 buf_we and cmd_strobe are never high for two consecutive cycles; buf_addr and buf_data hold their values between strobes.
REQ-028 An ss rise coincident with the edge that completes a byte: ss wins and no write or strobe is issued.

Reset
REQ-029 While reset_n is 0, all of the following hold: state=IDLE, osd_enable=0, buf_we=0, cmd_strobe=0, buf_addr=0, buf_data=0, cmd_byte=0, sync flops=0 except ss, which resets to 1.
REQ-030 Reset deassertion mid-transfer shall wait in IDLE for a fresh ss fall; no spurious edge is detected on the first cycle.

Structure
REQ-031 Shared package osd_pkg holds the opcode constants OSD_CMD_WRITE=5'b00100 and OSD_CMD_ENABLE=5'b01000, the state enumeration, and buffer address widths.
REQ-032 One sub-module, osd_sync_edge, provides the parameterised synchroniser with a rising-edge output; it is instantiated for sck, ss and sdi (no edge output used for sdi).

Verification
REQ-033 Send 0x41 with ss framing -> cmd_strobe once, cmd_byte=0x41, osd_enable=1. Send 0x40 -> osd_enable=0.
REQ-034 Send 0x23 then payload bytes 0x00..0x05 -> exactly 3 buf_we: (addr 0x180, data 0x01), (0x181, 0x03), (0x182, 0x05).
REQ-035 Send 0x20 then 260 bytes -> 128 writes with addr 0x000..0x07F and none at 0x080 or higher.
REQ-036 Raise ss after 0x21 plus 4 bits of a payload byte -> no buf_we; the next transfer 0x21, 0xAA, 0x55 writes 0x55 to 0x080.
REQ-037 Send command 0x10 plus payload -> no writes and osd_enable unchanged; assert reset_n=0 mid-payload -> all outputs reach their reset values asynchronously.
